cgra_tile_ctx_mem: RTL and testbench
====================================

// Module: cgra_tile_ctx_mem
// PURPOSE
//  Per-tile context memory and sequencer, directly downstream of the CSR loader.
//  Accepts KernelSize config words over the tile write port and stores them.
//  On a start command, replays active contexts 0..N-1 cyclically, one per cycle, to
//  the tile datapath. Honours tile back-pressure and reports completion.
// PARAMETERS
//  KernelSize  4   context slots per tile (power of 2, >=2); AW=$clog2(KernelSize)
//  IterWidth   16  width of iteration counter/limit
// PORTS
//  clk_i           in   1        clock
//  rst_ni          in   1        reset, asynchronous, active-low
//  cfg_addr_i      in   AW       context slot to write
//  cfg_data_i      in   cfg_t    config word {ctrl[48:43],pred[42],fu_in[41:30],outport[29:6],pred_in[5:0]}
//  cfg_wr_en_i     in   1        write enable
//  cfg_wr_valid_i  in   1        write valid
//  cfg_ready_o     out  1        write accepted this cycle (high only in IDLE)
//  run_start_i     in   1        start pulse (sampled in IDLE only)
//  run_stop_i      in   1        stop request (sampled in RUN only)
//  ctx_count_i     in   AW+1     active contexts N, legal 1..KernelSize, latched at start
//  iter_limit_i    in   IterWidth passes to run, 0=unlimited (only with macro)
//  stall_i         in   1        tile not consuming current context
//  ctx_o           out  cfg_t    current context word
//  ctx_idx_o       out  AW       slot index of ctx_o
//  ctx_valid_o     out  1        ctx_o valid
//  iter_o          out  IterWidth completed passes since start
//  loaded_o        out  1        every slot written since reset
//  busy_o          out  1        state==RUN
//  done_o          out  1        one-cycle pulse on RUN->IDLE
// BEHAVIOUR
//  Reset: memory, written-mask, ctx_o, ctx_idx_o, iter_o=0; all 1-bit outputs 0 except cfg_ready_o=1; state IDLE.
//  Write: cfg_wr_valid_i&&cfg_wr_en_i&&cfg_ready_o -> mem[addr]<=data, mask[addr]<=1 at next edge.
//   Same-slot rewrite overwrites. Write presented in RUN is not accepted (ready=0); source holds it.
//  FSM IDLE->RUN: run_start_i with 1<=ctx_count_i<=KernelSize. Illegal count -> ignored, stay IDLE.
//   Start doesn't require loaded_o; unwritten slots replay as 0.
//  Start at edge T: at T+1 busy_o=1, ctx_valid_o=1, ctx_idx_o=0, ctx_o=mem[0], iter_o=0.
//  RUN advance: !stall_i -> idx<=(idx==N-1)?0:idx+1, ctx_o<=mem[next]; wrap increments iter_o (saturates at max).
//   stall_i -> ctx_o, ctx_idx_o, iter_o held.
//  RUN->IDLE (next edge): run_stop_i (stall-independent), or limit reached (macro).
//   Then: ctx_valid_o=0, busy_o=0, done_o=1 for one cycle; ctx_o/idx cleared; iter_o holds final value.
//  Simultaneous stop + limit: single done_o pulse. run_start_i in RUN and run_stop_i in IDLE: ignored.
//  N=1: ctx 0 every cycle; each unstalled cycle is one pass.
//  Reset mid-RUN: immediate return to reset values; no done_o.
//  Write->start same cycle: write lands, start takes effect; mem[0] read at T+1 sees new data.
// CONFIGURATION
//  CGRA_CTX_ITER_LIMIT_EN defined: iter_limit_i port present, latched at start.
//   Nonzero L: RUN ends on the unstalled consumption of slot N-1 in pass L (iter_o becomes L); done_o next cycle.
//   L=0: runs until run_stop_i.
//  Undefined: iter_limit_i absent; RUN ends only on run_stop_i.
// STRUCTURE
//  Package cgra_pkg:
//   - cgra_cfg_t packed struct (ctrl 6, predicate 1, fu_in 12, outport 24, predicate_in 6)
//   - CGRA_CFG_W=49
//   - ctx_state_e {CTX_IDLE, CTX_RUN}
//  Sub-module cgra_ctx_seq: FSM, index/iteration counters, done pulse.
//  Top holds storage array, write port, and output registers.
// TESTING
//  1. Reset -> cfg_ready_o=1, loaded_o=0, ctx_valid_o=0, done_o=0, ctx_o=0.
//  2. Write slots 0..3 with 0x1..0x4 -> loaded_o=1 after 4th write.
//     Then start N=4 -> ctx_o 0x1,0x2,0x3,0x4,0x1 on consecutive cycles.
//  3. Start N=3, stall_i high 2 cycles on idx 1 -> idx sequence 0,1,1,1,2,0; iter_o=1 after wrap.
//  4. Write during RUN -> cfg_ready_o=0, mem unchanged.
//     run_stop_i -> next cycle ctx_valid_o=0, done_o=1 one cycle, cfg_ready_o=1.
//  5. Start with ctx_count_i=0 and =5 -> stays IDLE, busy_o=0.
//     rst_ni low mid-RUN -> all outputs at reset values, no done_o.
//  6. Macro on: N=2, L=3 -> 6 valid contexts, iter_o=3, done_o once.
//     Stop on the same final cycle -> still a single done_o.

Source files
------------

// File: rtl/cgra_pkg.sv
// Shared types for the CGRA tile context memory: the config word layout
// and the sequencer state encoding.
package cgra_pkg;

  localparam int CGRA_CFG_W = 49;

  // Config word, MSB first: ctrl[48:43], predicate[42], fu_in[41:30],
  // outport[29:6], predicate_in[5:0].
  typedef struct packed {
    logic [5:0]  ctrl;
    logic        predicate;
    logic [11:0] fu_in;
    logic [23:0] outport;
    logic [5:0]  predicate_in;
  } cgra_cfg_t;

  typedef enum logic {
    CTX_IDLE = 1'b0,
    CTX_RUN  = 1'b1
  } ctx_state_e;

endpackage

// File: rtl/cgra_tile_ctx_mem_if.sv
// Context write port from the CSR loader into a tile context memory.
// The source (master) holds a write until cfg_ready is seen high.
interface cgra_tile_ctx_mem_if
  import cgra_pkg::*;
#(
  parameter int KernelSize = 4
) ();

  localparam int AW = $clog2(KernelSize);

  logic [AW-1:0] cfg_addr;
  cgra_cfg_t     cfg_data;
  logic          cfg_wr_en;
  logic          cfg_wr_valid;
  logic          cfg_ready;

  modport master (
    output cfg_addr, cfg_data, cfg_wr_en, cfg_wr_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_addr, cfg_data, cfg_wr_en, cfg_wr_valid,
    output cfg_ready
  );

endinterface

// File: rtl/cgra_ctx_seq.sv
// Context sequencer: IDLE/RUN state machine, slot index and pass counter,
// and the one-cycle done pulse. Tells the top when to load the context
// register (load/next_idx) and when to clear it (clear).
// Optional iteration limit: CGRA_CTX_ITER_LIMIT_EN.
module cgra_ctx_seq
  import cgra_pkg::*;
#(
  parameter int KernelSize = 4,
  parameter int IterWidth  = 16,
  localparam int AW        = $clog2(KernelSize)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start,
  input  logic                 stop,
  input  logic [AW:0]          count,
`ifdef CGRA_CTX_ITER_LIMIT_EN
  input  logic [IterWidth-1:0] limit,
`endif
  input  logic                 stall,
  output logic                 busy,
  output logic [AW-1:0]        idx,
  output logic [IterWidth-1:0] iter,
  output logic                 done,
  output logic                 load,
  output logic                 clear,
  output logic [AW-1:0]        next_idx
);

  localparam logic [AW:0] KS = (AW+1)'(KernelSize);

  ctx_state_e           state_q, state_d;
  logic [AW:0]          n_q, n_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [IterWidth-1:0] iter_q, iter_d, iter_inc;
  logic                 done_q, done_d;
  logic                 last, wrap, limit_hit, count_ok;

  assign count_ok = (count != '0) && (count <= KS);
  assign last     = ({1'b0, idx_q} == (n_q - 1'b1));
  assign wrap     = !stall && last;
  assign iter_inc = (iter_q == '1) ? iter_q : iter_q + 1'b1;

`ifdef CGRA_CTX_ITER_LIMIT_EN
  logic [IterWidth-1:0] limit_q, limit_d;

  // Limit is sampled at start so the loader may change it mid-run.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) limit_q <= '0;
    else         limit_q <= limit_d;
  end

  // Final pass is the one whose wrap makes the pass count equal the limit.
  assign limit_hit = wrap && (limit_q != '0) && (iter_inc == limit_q);
`else
  assign limit_hit = 1'b0;
`endif

  // State, counters and done pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CTX_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      iter_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      iter_q  <= iter_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: start, advance/hold under stall, and stop/limit exit.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    iter_d  = iter_q;
    done_d  = 1'b0;
    load    = 1'b0;
    clear   = 1'b0;
`ifdef CGRA_CTX_ITER_LIMIT_EN
    limit_d = limit_q;
`endif
    case (state_q)
      CTX_IDLE: begin
        if (start && count_ok) begin
          state_d = CTX_RUN;
          n_d     = count;
          idx_d   = '0;
          iter_d  = '0;
          load    = 1'b1;
`ifdef CGRA_CTX_ITER_LIMIT_EN
          limit_d = limit;
`endif
        end
      end
      CTX_RUN: begin
        if (stop || limit_hit) begin
          // A stop landing on the final cycle still yields one done pulse.
          state_d = CTX_IDLE;
          idx_d   = '0;
          clear   = 1'b1;
          done_d  = 1'b1;
          if (wrap) iter_d = iter_inc;
        end else if (!stall) begin
          idx_d = last ? '0 : idx_q + 1'b1;
          load  = 1'b1;
          if (wrap) iter_d = iter_inc;
        end
      end
      default: state_d = CTX_IDLE;
    endcase
  end

  assign busy     = (state_q == CTX_RUN);
  assign idx      = idx_q;
  assign iter     = iter_q;
  assign done     = done_q;
  assign next_idx = idx_d;

endmodule

// File: rtl/cgra_tile_ctx_mem.sv
// Per-tile context memory and sequencer. Stores config words from the
// loader, then replays contexts 0..N-1 cyclically to the tile datapath,
// one per cycle, honouring tile stall. Optional pass limit is enabled
// with the CGRA_CTX_ITER_LIMIT_EN macro (adds iter_limit_i).
module cgra_tile_ctx_mem
  import cgra_pkg::*;
#(
  parameter int KernelSize = 4,
  parameter int IterWidth  = 16,
  localparam int AW        = $clog2(KernelSize)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  cgra_tile_ctx_mem_if.slave   cfg,
  input  logic                 run_start_i,
  input  logic                 run_stop_i,
  input  logic [AW:0]          ctx_count_i,
`ifdef CGRA_CTX_ITER_LIMIT_EN
  input  logic [IterWidth-1:0] iter_limit_i,
`endif
  input  logic                 stall_i,
  output cgra_cfg_t            ctx_o,
  output logic [AW-1:0]        ctx_idx_o,
  output logic                 ctx_valid_o,
  output logic [IterWidth-1:0] iter_o,
  output logic                 loaded_o,
  output logic                 busy_o,
  output logic                 done_o
);

  cgra_cfg_t             mem_q [KernelSize];
  logic [KernelSize-1:0] written_q;
  logic                  busy, load, clear, wr;
  logic [AW-1:0]         next_idx;
  cgra_cfg_t             rd_data;

  cgra_ctx_seq #(
    .KernelSize (KernelSize),
    .IterWidth  (IterWidth)
  ) u_seq (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start    (run_start_i),
    .stop     (run_stop_i),
    .count    (ctx_count_i),
`ifdef CGRA_CTX_ITER_LIMIT_EN
    .limit    (iter_limit_i),
`endif
    .stall    (stall_i),
    .busy     (busy),
    .idx      (ctx_idx_o),
    .iter     (iter_o),
    .done     (done_o),
    .load     (load),
    .clear    (clear),
    .next_idx (next_idx)
  );

  // Writes are only taken while idle so the replayed kernel never changes underfoot.
  assign cfg.cfg_ready = !busy;
  assign wr            = cfg.cfg_wr_valid && cfg.cfg_wr_en && cfg.cfg_ready;

  // Context storage and written-slot mask.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < KernelSize; i++) mem_q[i] <= '0;
      written_q <= '0;
    end else if (wr) begin
      mem_q[cfg.cfg_addr]     <= cfg.cfg_data;
      written_q[cfg.cfg_addr] <= 1'b1;
    end
  end

  // A write and a start in the same cycle: the first context sees the new word.
  assign rd_data = (wr && (cfg.cfg_addr == next_idx)) ? cfg.cfg_data : mem_q[next_idx];

  // Context output register: loads on start/advance, cleared on exit, held on stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    ctx_o <= '0;
    else if (clear) ctx_o <= '0;
    else if (load)  ctx_o <= rd_data;
  end

  assign ctx_valid_o = busy;
  assign busy_o      = busy;
  assign loaded_o    = &written_q;

endmodule

// File: tb/tb_cgra_tile_ctx_mem.sv
// Directed bench for cgra_tile_ctx_mem. Inputs change 1 ns after the
// rising edge and outputs are checked there too, i.e. away from the edge.
module tb_cgra_tile_ctx_mem;
  import cgra_pkg::*;

  localparam int KS = 4;
  localparam int IW = 16;
  localparam int AW = $clog2(KS);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run_start, run_stop, stall;
  logic [AW:0]   ctx_count;
`ifdef CGRA_CTX_ITER_LIMIT_EN
  logic [IW-1:0] iter_limit;
`endif
  cgra_cfg_t     ctx;
  logic [AW-1:0] ctx_idx;
  logic          ctx_valid, loaded, busy, done;
  logic [IW-1:0] iter;

  int vec_cnt = 0;
  int err_cnt = 0;

  cgra_tile_ctx_mem_if #(.KernelSize(KS)) cfg_if ();

  cgra_tile_ctx_mem #(.KernelSize(KS), .IterWidth(IW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cfg          (cfg_if.slave),
    .run_start_i  (run_start),
    .run_stop_i   (run_stop),
    .ctx_count_i  (ctx_count),
`ifdef CGRA_CTX_ITER_LIMIT_EN
    .iter_limit_i (iter_limit),
`endif
    .stall_i      (stall),
    .ctx_o        (ctx),
    .ctx_idx_o    (ctx_idx),
    .ctx_valid_o  (ctx_valid),
    .iter_o       (iter),
    .loaded_o     (loaded),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_slot(input logic [AW-1:0] a, input logic [48:0] d);
    cfg_if.cfg_addr     = a;
    cfg_if.cfg_data     = cgra_cfg_t'(d);
    cfg_if.cfg_wr_en    = 1'b1;
    cfg_if.cfg_wr_valid = 1'b1;
    tick();
    cfg_if.cfg_wr_en    = 1'b0;
    cfg_if.cfg_wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    vec_cnt++; if (cfg_if.cfg_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_ready got %b exp 1", cfg_if.cfg_ready); end
    vec_cnt++; if ({loaded, ctx_valid, done, busy} !== 4'b0000) begin err_cnt++; $display("FAIL reset_flags got %b exp 0000", {loaded, ctx_valid, done, busy}); end
    vec_cnt++; if (ctx !== cgra_cfg_t'(49'h0)) begin err_cnt++; $display("FAIL reset_ctx got %h exp 0", ctx); end
    vec_cnt++; if ({ctx_idx, iter} !== '0) begin err_cnt++; $display("FAIL reset_idx_iter got %h/%h exp 0/0", ctx_idx, iter); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_and_run();
    logic [48:0] exp_ctx [5] = '{49'h2, 49'h3, 49'h4, 49'h1, 49'h2};
    for (int i = 0; i < 4; i++) begin
      vec_cnt++; if (loaded !== 1'b0) begin err_cnt++; $display("FAIL loaded_early slot %0d got %b exp 0", i, loaded); end
      wr_slot(AW'(i), 49'(i + 1));
    end
    vec_cnt++; if (loaded !== 1'b1) begin err_cnt++; $display("FAIL loaded_after4 got %b exp 1", loaded); end
    ctx_count = 3'd4; run_start = 1'b1;
    tick();
    run_start = 1'b0;
    vec_cnt++; if ({busy, ctx_valid, done} !== 3'b110) begin err_cnt++; $display("FAIL start_flags got %b exp 110", {busy, ctx_valid, done}); end
    vec_cnt++; if (ctx !== cgra_cfg_t'(49'h1) || ctx_idx !== 2'd0 || iter !== 16'd0) begin err_cnt++; $display("FAIL start_ctx got %h/%0d/%0d exp 1/0/0", ctx, ctx_idx, iter); end
    for (int k = 0; k < 4; k++) begin
      tick();
      vec_cnt++; if (ctx !== cgra_cfg_t'(exp_ctx[k]) || ctx_idx !== AW'((k + 1) % 4)) begin err_cnt++; $display("FAIL run4 step %0d got %h/%0d exp %h/%0d", k, ctx, ctx_idx, exp_ctx[k], (k + 1) % 4); end
    end
    vec_cnt++; if (iter !== 16'd1) begin err_cnt++; $display("FAIL run4_iter got %0d exp 1", iter); end
    run_stop = 1'b1;
    tick();
    run_stop = 1'b0;
    vec_cnt++; if ({ctx_valid, busy, done, cfg_if.cfg_ready} !== 4'b0011) begin err_cnt++; $display("FAIL stop_flags got %b exp 0011", {ctx_valid, busy, done, cfg_if.cfg_ready}); end
    vec_cnt++; if (ctx !== cgra_cfg_t'(49'h0) || ctx_idx !== 2'd0 || iter !== 16'd1) begin err_cnt++; $display("FAIL stop_state got %h/%0d/%0d exp 0/0/1", ctx, ctx_idx, iter); end
    tick();
    vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL done_width got %b exp 0", done); end
  endtask

  task automatic test_stall();
    logic [1:0]  exp_idx [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
    logic        stl     [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] exp_it  [6] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
    ctx_count = 3'd3; run_start = 1'b1;
    tick();
    run_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      vec_cnt++; if (ctx_idx !== exp_idx[k] || ctx !== cgra_cfg_t'(49'(exp_idx[k] + 1)) || iter !== exp_it[k]) begin
        err_cnt++; $display("FAIL stall step %0d got idx %0d ctx %h iter %0d exp %0d/%0d/%0d", k, ctx_idx, ctx, iter, exp_idx[k], exp_idx[k] + 1, exp_it[k]);
      end
      stall = stl[k];
      if (k < 5) tick();
    end
    // stop while stalled still exits
    run_stop = 1'b1;
    tick();
    run_stop = 1'b0; stall = 1'b0;
    vec_cnt++; if ({done, busy, iter} !== {2'b10, 16'd1}) begin err_cnt++; $display("FAIL stall_stop got %b/%b/%0d exp 1/0/1", done, busy, iter); end
    tick();
  endtask

  task automatic test_write_in_run();
    ctx_count = 3'd2; run_start = 1'b1;
    tick();
    run_start = 1'b0;
    cfg_if.cfg_addr = 2'd0; cfg_if.cfg_data = cgra_cfg_t'(49'hAA);
    cfg_if.cfg_wr_en = 1'b1; cfg_if.cfg_wr_valid = 1'b1;
    vec_cnt++; if (cfg_if.cfg_ready !== 1'b0) begin err_cnt++; $display("FAIL run_ready got %b exp 0", cfg_if.cfg_ready); end
    tick(); tick();
    vec_cnt++; if (ctx_idx !== 2'd0 || ctx !== cgra_cfg_t'(49'h1)) begin err_cnt++; $display("FAIL run_mem_kept got %0d/%h exp 0/1", ctx_idx, ctx); end
    run_stop = 1'b1;
    tick();
    run_stop = 1'b0;
    vec_cnt++; if ({ctx_valid, done, cfg_if.cfg_ready} !== 3'b011) begin err_cnt++; $display("FAIL wr_stop got %b exp 011", {ctx_valid, done, cfg_if.cfg_ready}); end
    // held write lands in the same cycle as a new start with N=1
    ctx_count = 3'd1; run_start = 1'b1;
    tick();
    run_start = 1'b0;
    cfg_if.cfg_wr_en = 1'b0; cfg_if.cfg_wr_valid = 1'b0;
    vec_cnt++; if (ctx !== cgra_cfg_t'(49'hAA) || {busy, done} !== 2'b10 || iter !== 16'd0) begin err_cnt++; $display("FAIL wr_start_fwd got %h/%b/%0d exp aa/10/0", ctx, {busy, done}, iter); end
    tick(); tick();
    vec_cnt++; if (ctx !== cgra_cfg_t'(49'hAA) || ctx_idx !== 2'd0 || iter !== 16'd2) begin err_cnt++; $display("FAIL n1_pass got %h/%0d/%0d exp aa/0/2", ctx, ctx_idx, iter); end
    stall = 1'b1; run_stop = 1'b1;
    tick();
    stall = 1'b0; run_stop = 1'b0;
    vec_cnt++; if ({done, busy, iter} !== {2'b10, 16'd2}) begin err_cnt++; $display("FAIL n1_stop got %b/%b/%0d exp 1/0/2", done, busy, iter); end
    tick();
  endtask

  task automatic test_illegal_start();
    ctx_count = 3'd0; run_start = 1'b1;
    tick();
    vec_cnt++; if ({busy, ctx_valid} !== 2'b00) begin err_cnt++; $display("FAIL start_n0 got %b exp 00", {busy, ctx_valid}); end
    ctx_count = 3'd5;
    tick();
    run_start = 1'b0;
    vec_cnt++; if ({busy, ctx_valid} !== 2'b00) begin err_cnt++; $display("FAIL start_n5 got %b exp 00", {busy, ctx_valid}); end
    run_stop = 1'b1;
    tick();
    run_stop = 1'b0;
    vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL stop_in_idle got %b exp 0", done); end
  endtask

  task automatic test_reset_mid_run();
    ctx_count = 3'd4; run_start = 1'b1;
    tick();
    run_start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    vec_cnt++; if ({busy, ctx_valid, done, loaded, cfg_if.cfg_ready} !== 5'b00001) begin err_cnt++; $display("FAIL midrst_flags got %b exp 00001", {busy, ctx_valid, done, loaded, cfg_if.cfg_ready}); end
    vec_cnt++; if (ctx !== cgra_cfg_t'(49'h0) || ctx_idx !== 2'd0 || iter !== 16'd0) begin err_cnt++; $display("FAIL midrst_regs got %h/%0d/%0d exp 0/0/0", ctx, ctx_idx, iter); end
    tick();
    rst_n = 1'b1;
    tick();
    vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL midrst_done got %b exp 0", done); end
  endtask

`ifdef CGRA_CTX_ITER_LIMIT_EN
  task automatic test_iter_limit();
    logic [48:0] d [2] = '{49'h11, 49'h22};
    int          nvalid;
    wr_slot(2'd0, 49'h11);
    wr_slot(2'd1, 49'h22);
    for (int r = 0; r < 2; r++) begin
      nvalid = 0;
      iter_limit = 16'd3; ctx_count = 3'd2; run_start = 1'b1;
      tick();
      run_start = 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (ctx_valid === 1'b1) nvalid++;
        vec_cnt++; if (ctx_idx !== AW'(k % 2) || ctx !== cgra_cfg_t'(d[k % 2]) || iter !== 16'(k / 2) || done !== 1'b0) begin
          err_cnt++; $display("FAIL lim r%0d step %0d got %0d/%h/%0d/%b exp %0d/%h/%0d/0", r, k, ctx_idx, ctx, iter, done, k % 2, d[k % 2], k / 2);
        end
        if (r == 1 && k == 5) run_stop = 1'b1;
        tick();
      end
      run_stop = 1'b0;
      vec_cnt++; if (nvalid !== 6) begin err_cnt++; $display("FAIL lim_count r%0d got %0d exp 6", r, nvalid); end
      vec_cnt++; if ({done, ctx_valid, busy, iter} !== {3'b100, 16'd3}) begin err_cnt++; $display("FAIL lim_end r%0d got %b/%b/%b/%0d exp 1/0/0/3", r, done, ctx_valid, busy, iter); end
      tick();
      vec_cnt++; if ({done, busy} !== 2'b00) begin err_cnt++; $display("FAIL lim_single r%0d got %b exp 00", r, {done, busy}); end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    run_start = 1'b0; run_stop = 1'b0; stall = 1'b0; ctx_count = '0;
`ifdef CGRA_CTX_ITER_LIMIT_EN
    iter_limit = '0;
`endif
    cfg_if.cfg_addr = '0; cfg_if.cfg_data = '0;
    cfg_if.cfg_wr_en = 1'b0; cfg_if.cfg_wr_valid = 1'b0;
    test_reset();
    test_load_and_run();
    test_stall();
    test_write_in_run();
    test_illegal_start();
    test_reset_mid_run();
`ifdef CGRA_CTX_ITER_LIMIT_EN
    test_iter_limit();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
